// File: rtl/sram_pkg.sv
// sram_pkg: shared types and default timing for the SRAM controller.
// Byte-lane support is enabled with SRAM_CTRL_BYTE_EN.
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SU,
    WR_PW,
    WR_HD
  } sram_state_t;

  localparam int SRAM_ADDR_W_DEF   = 18;
  localparam int SRAM_DATA_W_DEF   = 16;
  localparam int SRAM_RD_WAIT_DEF  = 2;
  localparam int SRAM_WR_SETUP_DEF = 1;
  localparam int SRAM_WR_PULSE_DEF = 2;
  localparam int SRAM_WR_HOLD_DEF  = 1;
  localparam int SRAM_CNT_W        = 8;

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: request/response handshake between CPU and SRAM controller.
// req_be exists only when SRAM_CTRL_BYTE_EN is defined.
interface sram_ctrl_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W_DEF,
  parameter int DATA_W = SRAM_DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef SRAM_CTRL_BYTE_EN
  logic [DATA_W/8-1:0] req_be;
`endif
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
`ifdef SRAM_CTRL_BYTE_EN
    output req_be,
`endif
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
`ifdef SRAM_CTRL_BYTE_EN
    input  req_be,
`endif
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-word controller for an asynchronous SRAM.
// Define SRAM_CTRL_BYTE_EN to add req_be / sram_bl_n byte lanes.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W_DEF,
  parameter int DATA_W   = SRAM_DATA_W_DEF,
  parameter int RD_WAIT  = SRAM_RD_WAIT_DEF,
  parameter int WR_SETUP = SRAM_WR_SETUP_DEF,
  parameter int WR_PULSE = SRAM_WR_PULSE_DEF,
  parameter int WR_HOLD  = SRAM_WR_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
`ifdef SRAM_CTRL_BYTE_EN
  ,
  output logic [DATA_W/8-1:0] sram_bl_n
`endif
);

  localparam int CW = SRAM_CNT_W;
  localparam logic [CW-1:0] RD_CNT = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] SU_CNT = CW'(WR_SETUP - 1);
  localparam logic [CW-1:0] PW_CNT = CW'(WR_PULSE - 1);
  localparam logic [CW-1:0] HD_CNT = CW'(WR_HOLD - 1);

  sram_state_t       state;
  logic [CW-1:0]     wcnt;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              dq_oe;
  logic              ready_q;
  logic              rsp_q;
  logic              rsp_pend;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;

  // controller drives DQ only while a write sequence is active
  assign sram_dq = dq_oe ? wdata_q : {DATA_W{1'bz}};

  // sequencer with registered pin outputs and response strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      dq_oe     <= 1'b0;
      ready_q   <= 1'b1;
      rsp_q     <= 1'b0;
      rsp_pend  <= 1'b0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
`ifdef SRAM_CTRL_BYTE_EN
      sram_bl_n <= '1;
`endif
    end else begin
      rsp_q    <= rsp_pend;
      rsp_pend <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            ready_q   <= 1'b0;
            sram_addr <= bus.req_addr;
            sram_ce_n <= 1'b0;
            if (bus.req_we) begin
              state   <= WR_SU;
              wcnt    <= SU_CNT;
              wdata_q <= bus.req_wdata;
              dq_oe   <= 1'b1;
`ifdef SRAM_CTRL_BYTE_EN
              sram_bl_n <= ~bus.req_be;
`endif
            end else begin
              state     <= RD;
              wcnt      <= RD_CNT;
              sram_oe_n <= 1'b0;
`ifdef SRAM_CTRL_BYTE_EN
              sram_bl_n <= '0;
`endif
            end
          end
        end
        RD: begin
          if (wcnt == '0) begin
            rdata_q   <= sram_dq;
            rsp_pend  <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            ready_q   <= 1'b1;
            state     <= IDLE;
`ifdef SRAM_CTRL_BYTE_EN
            sram_bl_n <= '1;
`endif
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        WR_SU: begin
          if (wcnt == '0) begin
            sram_we_n <= 1'b0;
            wcnt      <= PW_CNT;
            state     <= WR_PW;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        WR_PW: begin
          if (wcnt == '0) begin
            sram_we_n <= 1'b1;
            wcnt      <= HD_CNT;
            state     <= WR_HD;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        WR_HD: begin
          if (wcnt == '0) begin
            sram_ce_n <= 1'b1;
            dq_oe     <= 1'b0;
            ready_q   <= 1'b1;
            state     <= IDLE;
`ifdef SRAM_CTRL_BYTE_EN
            sram_bl_n <= '1;
`endif
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl with a behavioural SRAM.
// Byte-lane vectors run when SRAM_CTRL_BYTE_EN is defined.
module tb_sram_ctrl;
  import sram_pkg::*;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int PULSE = 3;
  localparam int RD_LAT = SRAM_RD_WAIT_DEF + 1;
  localparam int WR_OCC = SRAM_WR_SETUP_DEF + PULSE
                        + SRAM_WR_HOLD_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wire  [DW-1:0] sram_dq;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
`ifdef SRAM_CTRL_BYTE_EN
  logic [DW/8-1:0] sram_bl_n;
  logic [DW/8-1:0] cur_be;
`endif

  sram_ctrl #(
    .ADDR_W(AW), .DATA_W(DW),
    .RD_WAIT(SRAM_RD_WAIT_DEF),
    .WR_SETUP(SRAM_WR_SETUP_DEF),
    .WR_PULSE(PULSE),
    .WR_HOLD(SRAM_WR_HOLD_DEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .sram_addr(sram_addr),
    .sram_dq(sram_dq),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
`ifdef SRAM_CTRL_BYTE_EN
    ,
    .sram_bl_n(sram_bl_n)
`endif
  );

  // behavioural asynchronous SRAM
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign sram_dq = (sram_ce_n == 1'b0 && sram_oe_n == 1'b0
                    && sram_we_n == 1'b1)
                   ? mem[sram_addr] : {DW{1'bz}};

  // SRAM latches the word on the WE rising edge
  always @(posedge sram_we_n) begin
    if (sram_ce_n == 1'b0) begin
`ifdef SRAM_CTRL_BYTE_EN
      for (int i = 0; i < DW/8; i++)
        if (!sram_bl_n[i])
          mem[sram_addr][8*i+:8] = sram_dq[8*i+:8];
`else
      mem[sram_addr] = sram_dq;
`endif
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_err = 0;
  int cont = 0;
  logic mon = 1'b0;
  logic [DW-1:0] rq[$];
  int rc[$];

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // response capture plus handshake/contention watch
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      rq.push_back(bus.rsp_rdata);
      rc.push_back(cyc);
    end
    if (mon) begin
      if (bus.req_ready &&
          (!sram_ce_n || !sram_oe_n || !sram_we_n))
        busy_err <= busy_err + 1;
      if (!sram_oe_n && dut.dq_oe)
        cont <= cont + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       input bit keep,
                       output int acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
`ifdef SRAM_CTRL_BYTE_EN
    bus.req_be    = cur_be;
`endif
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("ready_to", {31'b0, bus.req_ready}, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a,
                    input logic [DW-1:0] d);
    int acc, k, n_we, st_err;
    n_we = 0;
    st_err = 0;
    k = 0;
    issue(1'b1, a, d, 1'b0, acc);
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (!sram_we_n) n_we++;
      if (!sram_ce_n)
        if (sram_addr !== a || sram_dq !== d) st_err++;
      if (bus.req_ready) break;
    end
    chk("wr_occ", cyc - acc, WR_OCC);
    chk("we_low", n_we, PULSE);
    chk("wr_stable", st_err, 0);
  endtask

  task automatic rd(input logic [AW-1:0] a,
                    input logic [DW-1:0] exp);
    int acc, k;
    k = 0;
    issue(1'b0, a, '0, 1'b0, acc);
    while (rq.size() == 0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("rsp_seen", rq.size(), 1);
    if (rq.size() != 0) begin
      chk("rd_data", rq.pop_front(), exp);
      chk("rd_lat", rc.pop_front() - acc, RD_LAT);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ce"}, sram_ce_n, 1);
    chk({tag, "_oe"}, sram_oe_n, 1);
    chk({tag, "_we"}, sram_we_n, 1);
    chk({tag, "_dq"}, sram_dq, {16'h0, 16'hzzzz});
    chk({tag, "_rdy"}, bus.req_ready, 1);
    chk({tag, "_rv"}, bus.rsp_valid, 0);
    chk({tag, "_addr"}, sram_addr, 0);
  endtask

  initial begin
    int acc;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
`ifdef SRAM_CTRL_BYTE_EN
    cur_be = 2'b11;
    bus.req_be = cur_be;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rst0");
    chk("rst0_rdata", bus.rsp_rdata, 0);

    wr(18'h00012, 16'hBEEF);
    rd(18'h00012, 16'hBEEF);

    issue(1'b1, 18'h00100, 16'h5555, 1'b0, acc);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("rst1");

    wr(18'h00000, 16'h1111);
    wr(18'h3FFFF, 16'hA5A5);
    rd(18'h3FFFF, 16'hA5A5);
    rd(18'h00000, 16'h1111);

    mon = 1'b1;
    issue(1'b1, 18'h00200, 16'hC0DE, 1'b1, acc);
    issue(1'b0, 18'h00200, '0, 1'b1, acc);
    issue(1'b1, 18'h00201, 16'h7E57, 1'b1, acc);
    issue(1'b0, 18'h00201, '0, 1'b0, acc);
    repeat (8) @(negedge clk);
    mon = 1'b0;
    #1;
    chk("b2b_cnt", rq.size(), 2);
    if (rq.size() == 2) begin
      chk("b2b_rd0", rq.pop_front(), 16'hC0DE);
      chk("b2b_rd1", rq.pop_front(), 16'h7E57);
      void'(rc.pop_front());
      void'(rc.pop_front());
    end
    chk("b2b_busy", busy_err, 0);
    chk("b2b_cont", cont, 0);

`ifdef SRAM_CTRL_BYTE_EN
    cur_be = 2'b11;
    wr(18'h00040, 16'hFFFF);
    cur_be = 2'b10;
    wr(18'h00040, 16'h1234);
    cur_be = 2'b11;
    rd(18'h00040, 16'h12FF);
`endif

    repeat (4) @(negedge clk);
    #1;
    chk("rsp_extra", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
